dmem_responder: RTL and testbench

//  Data-memory responder serving the core's MEM-stage load/store requests (mem_rd/mem_wr, address, store data).

---
 rtl/core_pkg.sv | 19 +
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// word-alignment constant and a small address helper.
package core_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int WORD_ALIGN_BITS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // True when the byte-offset bits of an address select a whole word.
    function automatic logic is_word_aligned(input logic [WORD_ALIGN_BITS-1:0] lsb);
        return (lsb == '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM. The read data register only updates
// when a read is requested, so the last loaded word stays on rdata.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: store the word on the write-enable edge.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Read port: capture the addressed word when a read is requested.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one load or store,
// inserts WAIT_CYCLES wait states, then answers with a one-cycle mem_ready
// pulse while holding the pipeline via stall until the response cycle.
module dmem_responder
    import core_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] dir_mem,
    input  logic [DATA_W-1:0] dato_mem_in,
    output logic [DATA_W-1:0] dato_mem_out,
    output logic              mem_ready,
    output logic              addr_err,
    output logic              stall
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WORD_W = ADDR_W - WORD_ALIGN_BITS;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [WORD_W-1:0] LP_DEPTH    = WORD_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LP_CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    logic              r_rd;
    logic              r_wr;
    logic              r_err;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_dout_zero;

    logic              w_req;
    logic              w_accept;
    logic [WORD_W-1:0] w_word;
    logic              w_err;
    logic              w_ram_re;
    logic              w_ram_we;
    logic [IDX_W-1:0]  w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_req    = mem_rd | mem_wr;
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_word   = dir_mem[ADDR_W-1:WORD_ALIGN_BITS];
    assign w_err    = !is_word_aligned(dir_mem[WORD_ALIGN_BITS-1:0])
                    || (w_word >= LP_DEPTH)
                    || (mem_rd && mem_wr);

    // Next-state, wait counter and read strobe; the RAM read is issued on
    // the edge that enters RESP so the word is on rdata during RESP.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_ram_re   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_err) begin
                        w_next = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_next   = RESP;
                        w_ram_re = mem_rd;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = LP_CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_next   = RESP;
                    w_ram_re = r_rd;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Request control latch: kind of access and its error verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_rd  <= mem_rd;
            r_wr  <= mem_wr;
            r_err <= w_err;
        end
    end

    // Request data latch: word index and store data, held until the response.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= w_word[IDX_W-1:0];
            r_wdata <= dato_mem_in;
        end
    end

    // Output-zero flag: forced by reset and by an error response, cleared
    // when a legal load refreshes the RAM read register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout_zero <= 1'b1;
        end else if (w_accept && w_err) begin
            r_dout_zero <= 1'b1;
        end else if (w_ram_re) begin
            r_dout_zero <= 1'b0;
        end
    end

    // Stores commit on the edge leaving RESP; a reset on that edge drops them.
    assign w_ram_we   = rst_n && (r_state == RESP) && r_wr && !r_err;
    assign w_ram_addr = (r_state == IDLE) ? w_word[IDX_W-1:0] : r_idx;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (w_ram_we),
        .re    (w_ram_re && rst_n),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    assign mem_ready    = (r_state == RESP);
    assign addr_err     = mem_ready && r_err;
    assign stall        = ((r_state == IDLE) && w_req) || (r_state == WAIT);
    assign dato_mem_out = r_dout_zero ? '0 : w_ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states and one with
// none share the stimulus; a selector picks which one is being scored.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] dir_mem;
    logic [31:0] dato_mem_in;

    logic [31:0] dout2, dout0, w_dout;
    logic        rdy2, rdy0, w_rdy;
    logic        err2, err0, w_err;
    logic        stall2, stall0, w_stall;
    bit          sel = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dir_mem(dir_mem), .dato_mem_in(dato_mem_in), .dato_mem_out(dout2),
        .mem_ready(rdy2), .addr_err(err2), .stall(stall2));

    dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .dir_mem(dir_mem), .dato_mem_in(dato_mem_in), .dato_mem_out(dout0),
        .mem_ready(rdy0), .addr_err(err0), .stall(stall0));

    always_comb begin
        w_dout  = sel ? dout0  : dout2;
        w_rdy   = sel ? rdy0   : rdy2;
        w_err   = sel ? err0   : err2;
        w_stall = sel ? stall0 : stall2;
    end

    typedef struct {
        logic        err;
        logic [31:0] dout;
        bit          st;
        int          idx;
        logic [31:0] wd;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [31:0] model_mem [int];
    logic [31:0] model_last = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model of one request: error rules, load data, store hold.
    function automatic void push_exp(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int unsigned idx;
        idx  = a >> 2;
        e.err = (a[1:0] != 2'b00) || (idx >= 256) || (rd && wr);
        e.st  = wr;
        e.idx = int'(idx);
        e.wd  = d;
        if (e.err) begin
            e.dout     = '0;
            model_last = '0;
        end else if (rd) begin
            e.dout     = model_mem.exists(e.idx) ? model_mem[e.idx] : 32'h0;
            model_last = e.dout;
        end else begin
            e.dout = model_last;
        end
        sb.push_back(e);
    endfunction

    // Scoreboard: every response pulse is matched to the oldest expectation.
    always @(negedge clk) begin
        if (w_rdy === 1'b1) begin
            check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check_val("addr_err", {31'd0, w_err}, {31'd0, e_mon.err});
                check_val("dout", w_dout, e_mon.dout);
                if (e_mon.st && !e_mon.err) model_mem[e_mon.idx] = e_mon.wd;
            end
        end
    end

    // Single access starting just after a rising edge; inputs drop once accepted.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input int lat_exp);
        int n;
        mem_rd = rd; mem_wr = wr; dir_mem = a; dato_mem_in = d;
        push_exp(rd, wr, a, d);
        @(negedge clk);
        check_val("stall_req", {31'd0, w_stall}, 32'd1);
        @(posedge clk); #1;
        mem_rd = 1'b0; mem_wr = 1'b0; dir_mem = '0; dato_mem_in = '0;
        n = 1;
        forever begin
            @(negedge clk);
            if (w_rdy === 1'b1) break;
            check_val("stall_wait", {31'd0, w_stall}, 32'd1);
            n++;
            if (n > 20) break;
        end
        check_val("latency", 32'(n), 32'(lat_exp));
        check_val("stall_resp", {31'd0, w_stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    logic [31:0] b2b_addr [3];

    initial begin
        rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; dir_mem = '0; dato_mem_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("idle_dout", w_dout, 32'd0);
            check_val("idle_ready", {31'd0, w_rdy}, 32'd0);
            check_val("idle_err", {31'd0, w_err}, 32'd0);
            check_val("idle_stall", {31'd0, w_stall}, 32'd0);
        end
        @(posedge clk); #1;

        // background contents
        access(1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 3);
        access(1'b0, 1'b1, 32'h0000_0004, 32'h0000_1234, 3);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 3);

        // 2: store then load with two wait states
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3);

        // 3: misaligned, out of range, then a legal load
        access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1);
        access(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1);
        access(1'b1, 1'b0, 32'h0000_0000, 32'h0, 3);

        // 4: simultaneous read and write is rejected without touching memory
        access(1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555, 1);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3);

        // 5: reset during wait states drops the store
        mem_wr = 1'b1; dir_mem = 32'h0000_0020; dato_mem_in = 32'h1234_5678;
        @(posedge clk); #1;
        mem_wr = 1'b0; dir_mem = '0; dato_mem_in = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_last = '0;
        @(negedge clk);
        check_val("rst_dout", w_dout, 32'd0);
        check_val("rst_ready", {31'd0, w_rdy}, 32'd0);
        check_val("rst_err", {31'd0, w_err}, 32'd0);
        check_val("rst_stall", {31'd0, w_stall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3);

        // 6: zero wait states, loads held back to back
        sel = 1'b1;
        model_last = '0;
        b2b_addr[0] = 32'h0000_0010;
        b2b_addr[1] = 32'h0000_0000;
        b2b_addr[2] = 32'h0000_0004;
        mem_rd = 1'b1; dir_mem = b2b_addr[0];
        push_exp(1'b1, 1'b0, b2b_addr[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("b2b_idle_ready", {31'd0, w_rdy}, 32'd0);
            check_val("b2b_idle_stall", {31'd0, w_stall}, 32'd1);
            @(negedge clk);
            check_val("b2b_resp_ready", {31'd0, w_rdy}, 32'd1);
            check_val("b2b_resp_stall", {31'd0, w_stall}, 32'd0);
            @(posedge clk); #1;
            if (i < 2) begin
                dir_mem = b2b_addr[i+1];
                push_exp(1'b1, 1'b0, b2b_addr[i+1], 32'h0);
            end
        end
        mem_rd = 1'b0; dir_mem = '0;
        repeat (2) @(posedge clk);

        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
